div_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder engine that consumes divide requests issued by the execute stage: operands, func3 and rd address.
- Runs a radix-2 restoring division over XLEN iterations.
- Returns the result together with rd address and write enable for the register file.
- busy_o drives execute's hold request, stalling the pipeline until completion; ctrl's jump flush aborts an in-flight operation.

---
 rtl/div_unit_pkg.sv | 34 +++
 rtl/div_unit.sv | 196 +++++++++++++++++++
 tb/tb_div_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder engine.
// Holds the M-extension func3 codes and the latched request control payload.
package div_unit_pkg;

    localparam int unsigned FUNC3_W    = 3;
    localparam int unsigned REG_ADDR_W = 5;

    // func3 codes of the divide group (opcode shared with the R-type M ops)
    localparam logic [FUNC3_W-1:0] INST_DIV  = 3'b100;
    localparam logic [FUNC3_W-1:0] INST_DIVU = 3'b101;
    localparam logic [FUNC3_W-1:0] INST_REM  = 3'b110;
    localparam logic [FUNC3_W-1:0] INST_REMU = 3'b111;

    // Control fields carried alongside the datapath for the whole operation
    typedef struct packed {
        logic [FUNC3_W-1:0]    op;
        logic [REG_ADDR_W-1:0] rd;
        logic                  neg_q;
        logic                  neg_r;
    } div_ctrl_t;

    function automatic logic is_signed_op(input logic [FUNC3_W-1:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic is_rem_op(input logic [FUNC3_W-1:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

    function automatic logic is_div_op(input logic [FUNC3_W-1:0] op);
        return (op == INST_DIV) || (op == INST_DIVU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Holds the pipeline through busy_o and returns the result with rd for writeback.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [FUNC3_W-1:0]    op_i,
    input  logic [XLEN-1:0]       dividend_i,
    input  logic [XLEN-1:0]       divisor_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic [XLEN-1:0]       result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_wen_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    div_ctrl_t             ctrl_q, ctrl_d;
    logic [XLEN-1:0]       dvd_q, dvd_d;
    logic [XLEN-1:0]       dvs_q, dvs_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       quot_q, quot_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;

    logic [XLEN:0]         rem_sh;
    logic [XLEN:0]         diff;
    logic [XLEN-1:0]       step_rem;
    logic [XLEN-1:0]       step_quot;
    logic [XLEN-1:0]       fixed_res;
    logic                  op_signed;
    logic                  overflow;
    logic                  kill;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    // One restoring step: shift {rem,quot} left, trial-subtract, keep if nonnegative
    always_comb begin
        rem_sh = {rem_q, quot_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            step_rem  = diff[XLEN-1:0];
            step_quot = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem  = rem_sh[XLEN-1:0];
            step_quot = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    // Final sign fix-up applied on the last step
    always_comb begin
        if (is_rem_op(ctrl_q.op)) begin
            fixed_res = neg_if(step_rem, ctrl_q.neg_r);
        end else begin
            fixed_res = neg_if(step_quot, ctrl_q.neg_q);
        end
    end

    assign op_signed = is_signed_op(ctrl_q.op);
    assign overflow  = op_signed && (dvd_q == INT_MIN) && (dvs_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Next-state and next-output logic; result outputs default to zero every cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = '0;
        ready_d  = 1'b0;
        rd_out_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d      = S_START;
                    ctrl_d.op    = op_i;
                    ctrl_d.rd    = rd_addr_i;
                    ctrl_d.neg_q = 1'b0;
                    ctrl_d.neg_r = 1'b0;
                    dvd_d        = dividend_i;
                    dvs_d        = divisor_i;
                end
            end
            S_START: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (dvs_q == '0) begin
                    state_d  = S_END;
                    result_d = is_div_op(ctrl_q.op) ? '1 : dvd_q;
                    ready_d  = 1'b1;
                    rd_out_d = ctrl_q.rd;
                end else if (overflow) begin
                    state_d  = S_END;
                    result_d = is_div_op(ctrl_q.op) ? INT_MIN : '0;
                    ready_d  = 1'b1;
                    rd_out_d = ctrl_q.rd;
                end else begin
                    state_d      = S_CALC;
                    ctrl_d.neg_q = op_signed && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                    ctrl_d.neg_r = op_signed && dvd_q[XLEN-1];
                    quot_d       = mag(dvd_q, op_signed);
                    dvs_d        = mag(dvs_q, op_signed);
                    rem_d        = '0;
                    cnt_d        = '0;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = S_END;
                        result_d = fixed_res;
                        ready_d  = 1'b1;
                        rd_out_d = ctrl_q.rd;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_START) || (state_d == S_CALC);
    end

    // A flush arriving during END still suppresses the writeback in that cycle
    assign kill      = flush_i && (state_q == S_END);
    assign result_o  = kill ? '0 : result_q;
    assign ready_o   = ready_q && !kill;
    assign reg_wen_o = ready_q && !kill;
    assign rd_addr_o = kill ? '0 : rd_out_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results/latencies,
// one task per scenario.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] dividend_i = '0;
    logic [XLEN-1:0] divisor_i = '0;
    logic [4:0]      rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic            busy_o;
    logic [4:0]      rd_addr_o;
    logic            reg_wen_o;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        int              lat;
        int              t0;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    div_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .rd_addr_o  (rd_addr_o),
        .reg_wen_o  (reg_wen_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb_;
        logic signed [XLEN-1:0] sr;
        logic rem;
        logic sgn;
        sa  = a;
        sb_ = b;
        rem = (op == 3'b110) || (op == 3'b111);
        sgn = (op == 3'b100) || (op == 3'b110);
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            sr = rem ? (sa % sb_) : (sa / sb_);
            return sr;
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic sgn;
        sgn = (op == 3'b100) || (op == 3'b110);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Drive one request and push its expected outcome; returns #1 after the start edge
    task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        e.res = model(op, a, b);
        e.rd  = rd;
        e.lat = model_lat(op, a, b);
        e.t0  = cyc;
        sb.push_back(e);
    endtask

    // Wait (bounded) for ready_o, then compare against the oldest scoreboard entry
    task automatic collect(input string name);
        exp_t e;
        bit   got;
        e   = sb.pop_front();
        got = 1'b0;
        while (!got && (cyc - e.t0) < 45) begin
            @(posedge clk);
            #1;
            if (ready_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: ready_o never seen, required after %0d edges", name, e.lat);
        end else begin
            if ((cyc - e.t0) !== e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d edges, required %0d", name, cyc - e.t0, e.lat);
            end
            checks++;
            if (result_o !== e.res) begin
                errors++;
                $display("FAIL %s result: got %h, required %h", name, result_o, e.res);
            end
            checks++;
            if (rd_addr_o !== e.rd || reg_wen_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL %s wb: rd=%0d wen=%b busy=%b, required rd=%0d wen=1 busy=0",
                         name, rd_addr_o, reg_wen_o, busy_o, e.rd);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b0 || result_o !== '0 || rd_addr_o !== '0 || reg_wen_o !== 1'b0) begin
                errors++;
                $display("FAIL %s clear: ready=%b result=%h rd=%0d wen=%b, required all 0",
                         name, ready_o, result_o, rd_addr_o, reg_wen_o);
            end
        end
    endtask

    // Watch n edges and require that ready_o never rises
    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_o || reg_wen_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s: ready_o high %0d times, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0 || rd_addr_o !== '0 || reg_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b result=%h rd=%0d wen=%b, required all 0",
                     ready_o, busy_o, result_o, rd_addr_o, reg_wen_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        send(INST_DIVU, 32'd100, 32'd7, 5'd10);
        collect("divu_100_7");
        send(INST_REMU, 32'd100, 32'd7, 5'd10);
        collect("remu_100_7");
    endtask

    task automatic test_signed();
        send(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
        collect("div_m7_2");
        send(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
        collect("rem_m7_2");
        send(INST_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5);
        collect("div_7_m2");
        send(INST_REM, 32'd7, 32'hFFFF_FFFE, 5'd6);
        collect("rem_7_m2");
    endtask

    task automatic test_div_zero();
        send(INST_DIV, 32'h1234_5678, 32'd0, 5'd7);
        collect("div_by_zero");
        send(INST_REMU, 32'h1234_5678, 32'd0, 5'd8);
        collect("remu_by_zero");
    endtask

    task automatic test_overflow();
        send(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        collect("div_overflow");
        send(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        collect("rem_overflow");
        send(INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        collect("divu_big");
    endtask

    task automatic test_ignore_start();
        send(INST_DIVU, 32'd1000, 32'd9, 5'd13);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1; op_i = INST_REMU; dividend_i = 32'd55; divisor_i = 32'd4; rd_addr_i = 5'd20;
        repeat (3) @(negedge clk);
        start_i = 1'b0;
        collect("start_during_busy");
    endtask

    task automatic test_flush();
        exp_t dropped;
        send(INST_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd14);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        dropped = sb.pop_front();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc busy: got %b, required 0", busy_o);
        end
        expect_quiet("flush_calc_no_ready", 40);
        send(INST_DIVU, 32'd81, 32'd9, 5'd15);
        collect("after_flush");
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd9; divisor_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_idle busy: got %b, required 0", busy_o);
        end
        expect_quiet("flush_start_idle_no_ready", 40);
    endtask

    task automatic test_flush_end();
        exp_t e;
        bit   got;
        send(INST_DIV, 32'h1234_5678, 32'd0, 5'd16);
        e   = sb.pop_front();
        got = 1'b0;
        while (!got && (cyc - e.t0) < 45) begin
            @(posedge clk);
            #1;
            if (ready_o) got = 1'b1;
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (!got || ready_o !== 1'b0 || reg_wen_o !== 1'b0 || result_o !== '0) begin
            errors++;
            $display("FAIL flush_end: seen=%b ready=%b wen=%b result=%h, required seen=1 and 0/0/0",
                     got, ready_o, reg_wen_o, result_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_end_idle: ready=%b busy=%b, required 0/0", ready_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        send(INST_DIVU, 32'h0F0F_0F0F, 32'd5, 5'd17);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        dropped = sb.pop_front();
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0 || rd_addr_o !== '0 || reg_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b result=%h rd=%0d wen=%b, required all 0",
                     ready_o, busy_o, result_o, rd_addr_o, reg_wen_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd18);
        collect("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 3'b100 + 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = 32'hFFFF_FFFF;
            send(op, a, b, 5'(i + 1));
            collect("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_flush();
        test_flush_end();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
